vio_route_sequencer: RTL and testbench

Per-region route sequencer for the vFPGA stream switch. It drives the 14-bit `route_in` word for one region from a small programmable chain of route entries and advances to the next entry only on packet boundaries of that region's outgoing user stream. It also records the route word delivered with each packet arriving at the region. One instance sits beside each vFPGA region, between the region's control registers and the data switch.

---
 rtl/vio_route_pkg.sv | 14 +
 rtl/vio_route_table.sv | 29 ++
 rtl/vio_route_sequencer.sv | 170 +++++++++++++++++
 tb/tb_vio_route_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vio_route_pkg.sv
// Shared types and defaults for the per-region route sequencer.
package vio_route_pkg;

    localparam int ROUTE_BITS = 14;

    localparam logic [ROUTE_BITS-1:0] IDLE_ROUTE = 14'h0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        IN_PKT = 2'd2
    } route_seq_state_t;

endpackage

// File: rtl/vio_route_table.sv
// Route chain storage: one synchronous write port, one combinational read
// port. A write to the address being read is forwarded in the same cycle.
module vio_route_table #(
    parameter int N_ENTRIES  = 8,
    parameter int ROUTE_BITS = 14
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [$clog2(N_ENTRIES)-1:0] waddr,
    input  logic [ROUTE_BITS-1:0]        wdata,
    input  logic [$clog2(N_ENTRIES)-1:0] raddr,
    output logic [ROUTE_BITS-1:0]        rdata
);

    logic [ROUTE_BITS-1:0] mem [N_ENTRIES];

    // Entry storage, deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Write-first read so a start in the same cycle as a write sees new data.
    always_comb begin
        rdata = (we && (waddr == raddr)) ? wdata : mem[raddr];
    end

endmodule

// File: rtl/vio_route_sequencer.sv
// Per-region route sequencer: steps through a programmed chain of route
// words on tx packet boundaries and records the route of received packets.
module vio_route_sequencer #(
    parameter int                     N_ENTRIES  = 8,
    parameter int                     ROUTE_BITS = vio_route_pkg::ROUTE_BITS,
    parameter logic [ROUTE_BITS-1:0]  IDLE_ROUTE = vio_route_pkg::IDLE_ROUTE
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic                         cfg_we,
    input  logic [$clog2(N_ENTRIES)-1:0] cfg_addr,
    input  logic [ROUTE_BITS-1:0]        cfg_data,
    input  logic                         cfg_len_we,
    input  logic [$clog2(N_ENTRIES):0]   cfg_len,
    input  logic                         cfg_loop,
    input  logic                         cfg_start,
    input  logic                         cfg_stop,
    input  logic                         tx_tvalid,
    input  logic                         tx_tready,
    input  logic                         tx_tlast,
    output logic [ROUTE_BITS-1:0]        route_in,
    input  logic                         rx_tvalid,
    input  logic                         rx_tready,
    input  logic                         rx_tlast,
    input  logic [ROUTE_BITS-1:0]        route_out,
    output logic [ROUTE_BITS-1:0]        rx_route,
    output logic                         busy,
    output logic [$clog2(N_ENTRIES)-1:0] cur_idx,
    output logic [31:0]                  tx_pkt_cnt,
    output logic [31:0]                  rx_pkt_cnt,
    output logic                         cfg_err
);

    import vio_route_pkg::*;

    localparam int            AW      = $clog2(N_ENTRIES);
    localparam logic [AW:0]   LEN_MAX = (AW+1)'(N_ENTRIES);

    route_seq_state_t      state, state_nxt;
    logic [AW:0]           len_q;
    logic                  loop_q;
    logic                  stop_pend, stop_pend_nxt;
    logic [AW-1:0]         idx_nxt;
    logic [ROUTE_BITS-1:0] route_nxt;
    logic [ROUTE_BITS-1:0] tbl_rdata;
    logic                  tx_beat, tx_end, rx_beat;
    logic                  at_last, cfg_open, tbl_we, len_bad, adv;
    logic                  rx_first;

    assign tx_beat  = tx_tvalid & tx_tready;
    assign tx_end   = tx_beat & tx_tlast;
    assign rx_beat  = rx_tvalid & rx_tready;
    assign at_last  = ({1'b0, cur_idx} == (len_q - (AW+1)'(1)));
    assign cfg_open = (state == IDLE);
    assign tbl_we   = cfg_we & cfg_open;
    assign len_bad  = (cfg_len == '0) || (cfg_len > LEN_MAX);

    // The table is read at the index that will be current after this edge,
    // so route_in is already updated for a back-to-back next packet.
    vio_route_table #(
        .N_ENTRIES  (N_ENTRIES),
        .ROUTE_BITS (ROUTE_BITS)
    ) u_table (
        .clk   (aclk),
        .we    (tbl_we),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .raddr (idx_nxt),
        .rdata (tbl_rdata)
    );

    // State register plus the registered datapath and configuration.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state      <= IDLE;
            route_in   <= IDLE_ROUTE;
            cur_idx    <= '0;
            stop_pend  <= 1'b0;
            len_q      <= '0;
            loop_q     <= 1'b0;
            tx_pkt_cnt <= '0;
            cfg_err    <= 1'b0;
        end else begin
            state     <= state_nxt;
            route_in  <= route_nxt;
            cur_idx   <= idx_nxt;
            stop_pend <= stop_pend_nxt;
            if (adv) begin
                tx_pkt_cnt <= tx_pkt_cnt + 32'd1;
            end
            if (cfg_open && cfg_len_we && !len_bad) begin
                len_q  <= cfg_len;
                loop_q <= cfg_loop;
            end
            if ((!cfg_open && (cfg_we || cfg_len_we || cfg_start)) ||
                (cfg_open && cfg_len_we && len_bad) ||
                (cfg_open && cfg_start && (len_q == '0))) begin
                cfg_err <= 1'b1;
            end
        end
    end

    // Next-state: arming, packet tracking, stop handling and chain advance.
    always_comb begin
        state_nxt     = state;
        idx_nxt       = cur_idx;
        stop_pend_nxt = stop_pend;
        adv           = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_start && (len_q != '0)) begin
                    state_nxt = ARMED;
                    idx_nxt   = '0;
                end
            end
            ARMED: begin
                if (cfg_stop && !tx_end) begin
                    state_nxt = IDLE;
                end else if (tx_end) begin
                    adv = 1'b1;
                end else if (tx_beat) begin
                    state_nxt = IN_PKT;
                end
            end
            IN_PKT: begin
                if (tx_end) begin
                    adv = 1'b1;
                end else if (cfg_stop) begin
                    stop_pend_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (adv) begin
            if (stop_pend || cfg_stop || (at_last && !loop_q)) begin
                state_nxt     = IDLE;
                stop_pend_nxt = 1'b0;
            end else begin
                state_nxt = ARMED;
                idx_nxt   = at_last ? '0 : cur_idx + 1'b1;
            end
        end
    end

    // Outputs: next route word and busy flag derived from the state register.
    always_comb begin
        route_nxt = (state_nxt == IDLE) ? IDLE_ROUTE : tbl_rdata;
        busy      = (state != IDLE);
    end

    // Receive tap: capture the route of each packet's first beat and count packets.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rx_first   <= 1'b1;
            rx_route   <= '0;
            rx_pkt_cnt <= '0;
        end else if (rx_beat) begin
            if (rx_first) begin
                rx_route <= route_out;
            end
            if (rx_tlast) begin
                rx_first   <= 1'b1;
                rx_pkt_cnt <= rx_pkt_cnt + 32'd1;
            end else begin
                rx_first <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vio_route_sequencer.sv
// Self-checking bench for vio_route_sequencer: directed scenarios plus a
// randomized run against a behavioural chain model.
module tb_vio_route_sequencer;

    logic        aclk = 1'b0;
    logic        areset;
    logic        cfg_we, cfg_len_we, cfg_loop, cfg_start, cfg_stop;
    logic [2:0]  cfg_addr;
    logic [13:0] cfg_data;
    logic [3:0]  cfg_len;
    logic        tx_tvalid, tx_tready, tx_tlast;
    logic        rx_tvalid, rx_tready, rx_tlast;
    logic [13:0] route_out;
    logic [13:0] route_in, rx_route;
    logic        busy, cfg_err;
    logic [2:0]  cur_idx;
    logic [31:0] tx_pkt_cnt, rx_pkt_cnt;

    int total = 0;
    int bad   = 0;

    // Behavioural model of the chain.
    logic [13:0] m_ent [8];
    int          m_len, m_idx;
    bit          m_loop, m_on, m_inpkt, m_stop, m_err, m_rx_first;
    logic [13:0] m_route, m_rx_route;
    logic [31:0] m_txc, m_rxc;

    vio_route_sequencer dut (
        .aclk(aclk), .areset(areset),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_len_we(cfg_len_we), .cfg_len(cfg_len), .cfg_loop(cfg_loop),
        .cfg_start(cfg_start), .cfg_stop(cfg_stop),
        .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tlast(tx_tlast),
        .route_in(route_in),
        .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .rx_tlast(rx_tlast),
        .route_out(route_out), .rx_route(rx_route),
        .busy(busy), .cur_idx(cur_idx),
        .tx_pkt_cnt(tx_pkt_cnt), .rx_pkt_cnt(rx_pkt_cnt), .cfg_err(cfg_err)
    );

    always #5 aclk = ~aclk;

    task automatic model_reset();
        m_len = 0; m_idx = 0; m_loop = 0; m_on = 0; m_inpkt = 0; m_stop = 0;
        m_err = 0; m_rx_first = 1; m_route = 14'h0; m_rx_route = 14'h0;
        m_txc = 0; m_rxc = 0;
    endtask

    task automatic model_step();
        bit tx, fin;
        int old_len;
        tx  = tx_tvalid && tx_tready;
        fin = tx && tx_tlast;
        if (rx_tvalid && rx_tready) begin
            if (m_rx_first) m_rx_route = route_out;
            if (rx_tlast) begin
                m_rx_first = 1;
                m_rxc = m_rxc + 1;
            end else begin
                m_rx_first = 0;
            end
        end
        if (!m_on) begin
            old_len = m_len;
            if (cfg_we) m_ent[cfg_addr] = cfg_data;
            if (cfg_len_we) begin
                if (cfg_len == 0 || cfg_len > 8) m_err = 1;
                else begin
                    m_len  = cfg_len;
                    m_loop = cfg_loop;
                end
            end
            if (cfg_start) begin
                if (old_len == 0) m_err = 1;
                else begin
                    m_on = 1; m_inpkt = 0; m_idx = 0; m_route = m_ent[0];
                end
            end
        end else begin
            if (cfg_we || cfg_len_we || cfg_start) m_err = 1;
            if (!m_inpkt && cfg_stop && !fin) begin
                m_on = 0; m_route = 14'h0;
            end else if (fin) begin
                m_txc = m_txc + 1;
                m_inpkt = 0;
                if (m_stop || cfg_stop || (m_idx == m_len - 1 && !m_loop)) begin
                    m_on = 0; m_stop = 0; m_route = 14'h0;
                end else begin
                    m_idx = (m_idx + 1) % m_len;
                    m_route = m_ent[m_idx];
                end
            end else if (tx && !m_inpkt) begin
                m_inpkt = 1;
            end else if (m_inpkt && cfg_stop) begin
                m_stop = 1;
            end
        end
    endtask

    task automatic clear_inputs();
        cfg_we = 0; cfg_len_we = 0; cfg_start = 0; cfg_stop = 0;
        cfg_addr = 0; cfg_data = 0; cfg_len = 0; cfg_loop = 0;
        tx_tvalid = 0; tx_tlast = 0; tx_tready = 1;
        rx_tvalid = 0; rx_tlast = 0; rx_tready = 1; route_out = 0;
    endtask

    // One clock: advance the model with the current inputs, then the DUT.
    task automatic tick();
        model_step();
        @(posedge aclk);
        #1;
        cfg_we = 0; cfg_len_we = 0; cfg_start = 0; cfg_stop = 0;
    endtask

    task automatic do_reset();
        areset = 1;
        model_reset();
        @(posedge aclk);
        #1;
        areset = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        do_reset();
        total++; if (route_in !== 14'h0) begin bad++; $display("FAIL reset_route: got %h want 0000", route_in); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (cur_idx !== 3'd0) begin bad++; $display("FAIL reset_idx: got %0d want 0", cur_idx); end
        total++; if (tx_pkt_cnt !== 32'd0 || rx_pkt_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", tx_pkt_cnt, rx_pkt_cnt); end
        total++; if (cfg_err !== 1'b0 || rx_route !== 14'h0) begin bad++; $display("FAIL reset_err_rx: got %b/%h want 0/0000", cfg_err, rx_route); end
    endtask

    task automatic test_single();
        cfg_we = 1; cfg_addr = 0; cfg_data = 14'h0E3C;
        cfg_len_we = 1; cfg_len = 1; cfg_loop = 0;
        tick();
        cfg_start = 1;
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_armed: got %b want 1", busy); end
        for (int i = 0; i < 4; i++) begin
            tx_tvalid = 1; tx_tlast = (i == 3);
            total++; if (route_in !== 14'h0E3C) begin bad++; $display("FAIL single_route_beat%0d: got %h want 0e3c", i, route_in); end
            tick();
        end
        tx_tvalid = 0; tx_tlast = 0;
        total++; if (route_in !== 14'h0) begin bad++; $display("FAIL single_route_after: got %h want 0000", route_in); end
        total++; if (tx_pkt_cnt !== 32'd1) begin bad++; $display("FAIL single_txcnt: got %0d want 1", tx_pkt_cnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [13:0] exp_seq [5];
        exp_seq[0] = 14'h0100; exp_seq[1] = 14'h0200; exp_seq[2] = 14'h0300;
        exp_seq[3] = 14'h0100; exp_seq[4] = 14'h0200;
        for (int k = 0; k < 3; k++) begin
            cfg_we = 1; cfg_addr = 3'(k); cfg_data = exp_seq[k];
            tick();
        end
        cfg_len_we = 1; cfg_len = 3; cfg_loop = 1;
        tick();
        cfg_start = 1;
        tick();
        for (int p = 0; p < 5; p++) begin
            tx_tvalid = 1; tx_tlast = 1;
            total++; if (route_in !== exp_seq[p]) begin bad++; $display("FAIL b2b_route_pkt%0d: got %h want %h", p, route_in, exp_seq[p]); end
            tick();
        end
        tx_tvalid = 0; tx_tlast = 0;
        total++; if (cur_idx !== 3'd2) begin bad++; $display("FAIL b2b_idx: got %0d want 2", cur_idx); end
        total++; if (route_in !== 14'h0300 || tx_pkt_cnt !== 32'd6) begin bad++; $display("FAIL b2b_end: got %h/%0d want 0300/6", route_in, tx_pkt_cnt); end
        cfg_stop = 1;
        tick();
        total++; if (busy !== 1'b0 || route_in !== 14'h0) begin bad++; $display("FAIL b2b_stop_armed: got %b/%h want 0/0000", busy, route_in); end
    endtask

    task automatic test_stop_in_pkt();
        cfg_start = 1;
        tick();
        for (int b = 0; b < 3; b++) begin
            tx_tvalid = 1; tx_tlast = (b == 2); cfg_stop = (b == 1);
            total++; if (route_in !== 14'h0100) begin bad++; $display("FAIL stop_hold_beat%0d: got %h want 0100", b, route_in); end
            tick();
        end
        total++; if (busy !== 1'b0 || route_in !== 14'h0) begin bad++; $display("FAIL stop_idle: got %b/%h want 0/0000", busy, route_in); end
        tx_tvalid = 1; tx_tlast = 1;
        tick();
        tx_tvalid = 0; tx_tlast = 0;
        total++; if (route_in !== 14'h0 || tx_pkt_cnt !== 32'd7) begin bad++; $display("FAIL stop_next_pkt: got %h/%0d want 0000/7", route_in, tx_pkt_cnt); end
    endtask

    task automatic test_errors();
        cfg_start = 1;
        tick();
        total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL err_pre: got %b want 0", cfg_err); end
        cfg_we = 1; cfg_addr = 1; cfg_data = 14'h3FFF;
        tick();
        total++; if (cfg_err !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL err_we_armed: got %b/%b want 1/1", cfg_err, busy); end
        cfg_stop = 1;
        tick();
        cfg_len_we = 1; cfg_len = 2; cfg_loop = 0;
        tick();
        cfg_start = 1;
        tick();
        tx_tvalid = 1; tx_tlast = 1;
        tick();
        total++; if (route_in !== 14'h0200) begin bad++; $display("FAIL err_table_kept: got %h want 0200", route_in); end
        tick();
        tx_tvalid = 0; tx_tlast = 0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL err_len2_end: got %b want 0", busy); end
        do_reset();
        cfg_start = 1;
        tick();
        total++; if (busy !== 1'b0 || cfg_err !== 1'b1) begin bad++; $display("FAIL err_start_len0: got %b/%b want 0/1", busy, cfg_err); end
        do_reset();
        cfg_len_we = 1; cfg_len = 9; cfg_loop = 0;
        tick();
        total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL err_len9: got %b want 1", cfg_err); end
        cfg_start = 1;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL err_len9_kept: got %b want 0", busy); end
    endtask

    task automatic test_rx_capture();
        logic [13:0] vals [5];
        logic        lasts [5];
        do_reset();
        vals[0] = 14'h0A0F; vals[1] = 14'h1111; vals[2] = 14'h2222;
        vals[3] = 14'h0B1F; vals[4] = 14'h3333;
        lasts[0] = 0; lasts[1] = 0; lasts[2] = 1; lasts[3] = 0; lasts[4] = 1;
        for (int i = 0; i < 5; i++) begin
            rx_tready = 0; rx_tvalid = 1; route_out = 14'h1FFF;
            tick();
            rx_tready = 1; rx_tlast = lasts[i]; route_out = vals[i];
            tick();
            if (i == 1) begin
                total++; if (rx_route !== 14'h0A0F) begin bad++; $display("FAIL rx_first_pkt: got %h want 0a0f", rx_route); end
            end
        end
        rx_tvalid = 0; rx_tlast = 0;
        total++; if (rx_route !== 14'h0B1F) begin bad++; $display("FAIL rx_route: got %h want 0b1f", rx_route); end
        total++; if (rx_pkt_cnt !== 32'd2) begin bad++; $display("FAIL rx_cnt: got %0d want 2", rx_pkt_cnt); end
    endtask

    task automatic test_reset_mid();
        cfg_we = 1; cfg_addr = 0; cfg_data = 14'h0E3C;
        cfg_len_we = 1; cfg_len = 1;
        tick();
        cfg_start = 1;
        tick();
        tx_tvalid = 1; tx_tlast = 0;
        tick();
        #3;
        areset = 1;
        model_reset();
        #1;
        total++; if (route_in !== 14'h0 || busy !== 1'b0 || tx_pkt_cnt !== 32'd0) begin bad++; $display("FAIL rstmid_async: got %h/%b/%0d want 0000/0/0", route_in, busy, tx_pkt_cnt); end
        tx_tvalid = 0;
        @(negedge aclk);
        areset = 0;
        @(posedge aclk);
        #1;
        cfg_len_we = 1; cfg_len = 1; cfg_loop = 0;
        tick();
        cfg_we = 1; cfg_addr = 0; cfg_data = 14'h1A5A; cfg_start = 1;
        tick();
        total++; if (route_in !== 14'h1A5A || busy !== 1'b1) begin bad++; $display("FAIL rstmid_bypass_start: got %h/%b want 1a5a/1", route_in, busy); end
        tx_tvalid = 1; tx_tlast = 0;
        tick();
        tx_tlast = 1;
        tick();
        tx_tvalid = 0; tx_tlast = 0;
        total++; if (tx_pkt_cnt !== 32'd1 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_after: got %0d/%b want 1/0", tx_pkt_cnt, busy); end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            cfg_we = 1; cfg_addr = 3'(k); cfg_data = 14'($urandom);
            tick();
        end
        cfg_len_we = 1; cfg_len = 4'($urandom_range(1, 8)); cfg_loop = 1'($urandom_range(0, 1));
        tick();
        for (int c = 0; c < 600; c++) begin
            tx_tvalid  = ($urandom_range(0, 9) < 6);
            tx_tready  = ($urandom_range(0, 9) < 8);
            tx_tlast   = ($urandom_range(0, 9) < 4);
            rx_tvalid  = ($urandom_range(0, 9) < 5);
            rx_tready  = ($urandom_range(0, 9) < 7);
            rx_tlast   = ($urandom_range(0, 9) < 3);
            route_out  = 14'($urandom);
            cfg_stop   = ($urandom_range(0, 99) < 4);
            cfg_start  = ($urandom_range(0, 99) < 12);
            cfg_we     = ($urandom_range(0, 99) < 5);
            cfg_addr   = 3'($urandom);
            cfg_data   = 14'($urandom);
            cfg_len_we = ($urandom_range(0, 99) < 3);
            cfg_len    = 4'($urandom_range(0, 9));
            cfg_loop   = 1'($urandom_range(0, 1));
            tick();
            total++; if (route_in !== m_route) begin bad++; $display("FAIL rand_route c%0d: got %h want %h", c, route_in, m_route); end
            total++; if (busy !== m_on || cur_idx !== 3'(m_idx)) begin bad++; $display("FAIL rand_busy_idx c%0d: got %b/%0d want %b/%0d", c, busy, cur_idx, m_on, m_idx); end
            total++; if (tx_pkt_cnt !== m_txc || rx_pkt_cnt !== m_rxc) begin bad++; $display("FAIL rand_cnt c%0d: got %0d/%0d want %0d/%0d", c, tx_pkt_cnt, rx_pkt_cnt, m_txc, m_rxc); end
            total++; if (rx_route !== m_rx_route || cfg_err !== m_err) begin bad++; $display("FAIL rand_rx_err c%0d: got %h/%b want %h/%b", c, rx_route, cfg_err, m_rx_route, m_err); end
        end
        clear_inputs();
    endtask

    initial begin
        areset = 0;
        clear_inputs();
        #2;
        test_reset();
        test_single();
        test_back_to_back();
        test_stop_in_pkt();
        test_errors();
        test_rx_capture();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
